// File: rtl/lsu_wb.sv
// lsu_wb: load/store unit feeding the register file write port.
// One blocking transaction at a time: decode, one word-aligned bus access,
// then load alignment/extension and a single-cycle completion.
// Build option: define LSU_TIMEOUT_EN to add a bus watchdog that aborts
// REQ/RSP after TIMEOUT_CYCLES cycles with err=1.
//
//  state | meaning
//  IDLE  | req_ready=1, waiting for an op from execute
//  REQ   | mem_valid=1, bus request held until mem_ready
//  RSP   | waiting for mem_rvalid (read data or write ack)
//  DONE  | one-cycle done pulse, optional write-back, err qualifies done
module lsu_wb #(
  parameter int N_REGS         = 16,
  parameter int REG_ID_W       = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [REG_ID_W-1:0] req_rd,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31:0]         mem_addr,
  output logic                mem_wen,
  output logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_wdata,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                wb_wen,
  output logic [REG_ID_W-1:0] wb_rd,
  output logic [31:0]         wb_wdata,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t state, state_nxt;

  logic [31:0]         addr_q;
  logic                store_q;
  logic [2:0]          f3_q;
  logic [REG_ID_W-1:0] rd_q;
  logic [3:0]          strb_q;
  logic [31:0]         wd_q;
  logic                wb_ok_q;
  logic                err_q;
  logic [31:0]         ld_q;

  logic                req_illegal;
  logic                req_misal;
  logic                req_wb_ok;
  logic [3:0]          req_strb;
  logic [31:0]         req_lane;
  logic [31:0]         rd_shift;
  logic [31:0]         ld_ext;
  logic                timeout;

`ifdef LSU_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMR_W-1:0] tmr_q;

  // Watchdog down-counter: preloaded while idle, terminal count in REQ/RSP aborts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      tmr_q <= '0;
    else if (state == IDLE)
      tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
    else if ((state == REQ || state == RSP) && tmr_q != '0)
      tmr_q <= tmr_q - 1'b1;
  end

  assign timeout = (state == REQ || state == RSP) && (tmr_q == '0);
`else
  // No watchdog; the term keeps the limit parameter referenced in this build.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Decode the incoming op: legality, alignment, byte lanes and write-back eligibility.
  always_comb begin
    req_illegal = 1'b0;
    req_misal   = 1'b0;
    req_strb    = 4'b0000;
    req_lane    = 32'h0;
    if (req_store)
      req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    case (req_funct3[1:0])
      2'b01:   req_misal = req_addr[0];
      2'b10:   req_misal = |req_addr[1:0];
      default: req_misal = 1'b0;
    endcase
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          req_strb = 4'b0001 << req_addr[1:0];
          req_lane = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          req_strb = req_addr[1] ? 4'b1100 : 4'b0011;
          req_lane = {2{req_wdata[15:0]}};
        end
        default: begin
          req_strb = 4'b1111;
          req_lane = req_wdata;
        end
      endcase
    end
    req_wb_ok = !req_store && (req_rd != '0) && (int'(req_rd) < N_REGS);
  end

  // Pick the addressed byte/halfword out of the read word and extend it.
  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = (req_illegal || req_misal) ? DONE : REQ;
      end
      REQ: begin
        mem_valid = 1'b1;
        if (timeout)
          state_nxt = DONE;
        else if (mem_ready)
          state_nxt = RSP;
      end
      RSP: begin
        if (timeout || mem_rvalid)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Op capture at accept, load result capture in RSP, error flag from decode or watchdog.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= 32'h0;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      rd_q    <= '0;
      strb_q  <= 4'b0000;
      wd_q    <= 32'h0;
      wb_ok_q <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 32'h0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        store_q <= req_store;
        f3_q    <= req_funct3;
        rd_q    <= req_rd;
        strb_q  <= req_strb;
        wd_q    <= req_lane;
        wb_ok_q <= req_wb_ok;
        err_q   <= req_illegal || req_misal;
      end
      if (timeout)
        err_q <= 1'b1;
      else if (state == RSP && mem_rvalid)
        ld_q <= ld_ext;
    end
  end

  // Bus fields only carry the captured op while the request is up.
  assign mem_addr  = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wen   = mem_valid & store_q;
  assign mem_wstrb = mem_valid ? strb_q : 4'b0000;
  assign mem_wdata = mem_valid ? wd_q : 32'h0;

  assign err      = done & err_q;
  assign wb_wen   = done & wb_ok_q & ~err_q;
  assign wb_rd    = wb_wen ? rd_q : '0;
  assign wb_wdata = wb_wen ? ld_q : 32'h0;

endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: directed self-checking bench for lsu_wb.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_lsu_wb;

`ifdef LSU_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_wen, done, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;

  int errors = 0;
  int checks = 0;

  lsu_wb #(.N_REGS(16), .REG_ID_W(5), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
  endtask

  // Zero-wait transaction; returns what the bus saw in cycle 1 and the DONE-cycle outputs.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        output logic mv, output logic [31:0] ma, output logic mwen,
                        output logic [3:0] ws, output logic [31:0] mwd,
                        output logic dn, output logic er, output logic wen,
                        output logic [4:0] ord, output logic [31:0] owd);
    drive(st, f3, a, wd, rd);
    tick;
    req_valid = 1'b0;
    mv = mem_valid; ma = mem_addr; mwen = mem_wen; ws = mem_wstrb; mwd = mem_wdata;
    mem_ready = 1'b1;
    tick;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick;
    mem_rvalid = 1'b0;
    dn = done; er = err; wen = wb_wen; ord = wb_rd; owd = wb_wdata;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if ({mem_valid, mem_wen, wb_wen, done, err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_valid, mem_wen, wb_wen, done, err}); end
    checks++; if ({mem_addr, mem_wstrb, mem_wdata, wb_rd, wb_wdata} !== 105'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wstrb, mem_wdata, wb_rd, wb_wdata}); end
    @(negedge clock);
    reset = 1'b0;
    tick;
  endtask

  task automatic test_lw;
    drive(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_c0_ready: got %b want 1", req_ready); end
    tick;
    req_valid = 1'b0;
    checks++; if ({mem_valid, mem_wen, req_ready, done} !== 4'b1000) begin errors++; $display("FAIL lw_c1_ctrl: got %b want 1000", {mem_valid, mem_wen, req_ready, done}); end
    checks++; if (mem_addr !== 32'h100 || mem_wstrb !== 4'b0000) begin errors++; $display("FAIL lw_c1_bus: got %h/%b want 00000100/0000", mem_addr, mem_wstrb); end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    checks++; if ({mem_valid, done} !== 2'b00) begin errors++; $display("FAIL lw_c2_ctrl: got %b want 00", {mem_valid, done}); end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick;
    mem_rvalid = 1'b0;
    checks++; if ({done, err, wb_wen} !== 3'b101) begin errors++; $display("FAIL lw_c3_flags: got %b want 101", {done, err, wb_wen}); end
    checks++; if (wb_rd !== 5'd5 || wb_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_c3_wb: got %0d/%h want 5/deadbeef", wb_rd, wb_wdata); end
    tick;
    checks++; if ({done, wb_wen, req_ready} !== 3'b001) begin errors++; $display("FAIL lw_c4_idle: got %b want 001", {done, wb_wen, req_ready}); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [7];
    logic [31:0] adr [7];
    logic [31:0] exp [7];
    logic mv, mwen, dn, er, wen;
    logic [31:0] ma, mwd, owd;
    logic [3:0] ws;
    logic [4:0] ord;
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
    adr = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h102};
    exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h00000022, 32'h00002233, 32'h00000011};
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, f3s[i], adr[i], 32'h0, 5'd3, 32'h80112233, mv, ma, mwen, ws, mwd, dn, er, wen, ord, owd);
      checks++; if (ma !== {adr[i][31:2], 2'b00} || mwen !== 1'b0) begin errors++; $display("FAIL ext_bus[%0d]: got %h/%b want %h/0", i, ma, mwen, {adr[i][31:2], 2'b00}); end
      checks++; if ({dn, er, wen} !== 3'b101 || ord !== 5'd3 || owd !== exp[i]) begin errors++; $display("FAIL ext_data[%0d]: got %b %0d %h want 101 3 %h", i, {dn, er, wen}, ord, owd, exp[i]); end
    end
  endtask

  task automatic test_store;
    logic [2:0]  f3s [4];
    logic [31:0] adr [4];
    logic [31:0] wds [4];
    logic [31:0] eadr [4];
    logic [3:0]  estb [4];
    logic [31:0] ewd [4];
    logic mv, mwen, dn, er, wen;
    logic [31:0] ma, mwd, owd;
    logic [3:0] ws;
    logic [4:0] ord;
    f3s  = '{3'b001, 3'b000, 3'b010, 3'b000};
    adr  = '{32'h206, 32'h101, 32'h300, 32'h203};
    wds  = '{32'h0000ABCD, 32'h123456A5, 32'h12345678, 32'h000000FF};
    eadr = '{32'h204, 32'h100, 32'h300, 32'h200};
    estb = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    ewd  = '{32'hABCDABCD, 32'hA5A5A5A5, 32'h12345678, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, f3s[i], adr[i], wds[i], 5'd6, 32'h0, mv, ma, mwen, ws, mwd, dn, er, wen, ord, owd);
      checks++; if ({mv, mwen} !== 2'b11 || ma !== eadr[i] || ws !== estb[i] || mwd !== ewd[i]) begin errors++; $display("FAIL store_bus[%0d]: got %b %h %b %h want 11 %h %b %h", i, {mv, mwen}, ma, ws, mwd, eadr[i], estb[i], ewd[i]); end
      checks++; if ({dn, er, wen} !== 3'b100) begin errors++; $display("FAIL store_done[%0d]: got %b want 100", i, {dn, er, wen}); end
    end
  endtask

  task automatic test_errors;
    logic        sts [8];
    logic [2:0]  f3s [8];
    logic [31:0] adr [8];
    sts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    f3s = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b011, 3'b001};
    adr = '{32'h101, 32'h103, 32'h102, 32'h0, 32'h0, 32'h0, 32'h0, 32'h201};
    for (int i = 0; i < 8; i++) begin
      drive(sts[i], f3s[i], adr[i], 32'h55, 5'd4);
      tick;
      req_valid = 1'b0;
      mem_ready = 1'b1;
      checks++; if ({mem_valid, done, err, wb_wen} !== 4'b0110) begin errors++; $display("FAIL err_c1[%0d]: got %b want 0110", i, {mem_valid, done, err, wb_wen}); end
      tick;
      mem_ready = 1'b0;
      checks++; if ({mem_valid, done, req_ready} !== 3'b001) begin errors++; $display("FAIL err_c2[%0d]: got %b want 001", i, {mem_valid, done, req_ready}); end
    end
  endtask

  task automatic test_rd_limits;
    logic [4:0] rds [4];
    logic       ew  [4];
    logic mv, mwen, dn, er, wen;
    logic [31:0] ma, mwd, owd;
    logic [3:0] ws;
    logic [4:0] ord;
    rds = '{5'd0, 5'd16, 5'd15, 5'd31};
    ew  = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 3'b010, 32'h40, 32'h0, rds[i], 32'h0BADF00D, mv, ma, mwen, ws, mwd, dn, er, wen, ord, owd);
      checks++; if ({dn, er, wen} !== {1'b1, 1'b0, ew[i]}) begin errors++; $display("FAIL rd_limit[%0d]: got %b want 10%b", i, {dn, er, wen}, ew[i]); end
    end
  endtask

  task automatic test_stall;
    logic saw_done;
    drive(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd0);
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_valid, mem_wen} !== 2'b11 || mem_addr !== 32'h40 || mem_wstrb !== 4'hF || mem_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_hold[%0d]: got %b %h %b %h", i, {mem_valid, mem_wen}, mem_addr, mem_wstrb, mem_wdata); end
      mem_rvalid = 1'b1;
      tick;
      mem_rvalid = 1'b0;
    end
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || done !== 1'b0) begin errors++; $display("FAIL stall_rvalid_ignored: got %b %h %b want 1 40 0", mem_valid, mem_addr, done); end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      saw_done |= done | mem_valid;
      tick;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL stall_rsp_wait: got %b want 0", saw_done); end
    mem_rvalid = 1'b1;
    tick;
    mem_rvalid = 1'b0;
    checks++; if ({done, err, wb_wen} !== 3'b100) begin errors++; $display("FAIL stall_done: got %b want 100", {done, err, wb_wen}); end
    tick;
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    drive(1'b0, 3'b010, 32'h80, 32'h0, 5'd7);
    tick;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if ({req_ready, mem_valid, done, wb_wen} !== 4'b1000) begin errors++; $display("FAIL rst_mid: got %b want 1000", {req_ready, mem_valid, done, wb_wen}); end
    @(negedge clock);
    reset = 1'b0;
    tick;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick;
    mem_rvalid = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      saw_done |= done | wb_wen;
      tick;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid: got %b want 0", saw_done); end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
    tick;
    mem_ready = 1'b1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", req_ready); end
    tick;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    tick;
    mem_rvalid = 1'b0;
    checks++; if ({done, wb_wen} !== 2'b11 || wb_rd !== 5'd1 || wb_wdata !== 32'h11111111) begin errors++; $display("FAIL b2b_first: got %b %0d %h want 11 1 11111111", {done, wb_wen}, wb_rd, wb_wdata); end
    drive(1'b0, 3'b010, 32'h14, 32'h0, 5'd2);
    tick;
    checks++; if ({req_ready, mem_valid} !== 2'b10) begin errors++; $display("FAIL b2b_c4: got %b want 10", {req_ready, mem_valid}); end
    tick;
    req_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h14) begin errors++; $display("FAIL b2b_second_req: got %b %h want 1 00000014", mem_valid, mem_addr); end
    mem_ready = 1'b1;
    tick;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h22222222;
    tick;
    mem_rvalid = 1'b0;
    checks++; if ({done, wb_wen} !== 2'b11 || wb_rd !== 5'd2 || wb_wdata !== 32'h22222222) begin errors++; $display("FAIL b2b_second: got %b %0d %h want 11 2 22222222", {done, wb_wen}, wb_rd, wb_wdata); end
    tick;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    drive(1'b0, 3'b010, 32'h0, 32'h0, 5'd4);
    tick;
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if ({mem_valid, done} !== 2'b10) begin errors++; $display("FAIL to_wait[%0d]: got %b want 10", i, {mem_valid, done}); end
      tick;
    end
    checks++; if ({mem_valid, done, err, wb_wen} !== 4'b0110) begin errors++; $display("FAIL to_done: got %b want 0110", {mem_valid, done, err, wb_wen}); end
    tick;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'd0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    test_reset;
    test_lw;
    test_load_ext;
    test_store;
    test_errors;
    test_rd_limits;
    test_stall;
    test_reset_mid;
    test_back_to_back;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store unit that sits directly upstream of the register file write port.
- Accepts one load or store from execute, runs a single word-aligned memory bus transaction and aligns/extends load data.
- Drives the register file write port (wb_wen/wb_rd/wb_wdata) for loads.
- One transaction in flight; blocking, multi-cycle.

Parameters:
- N_REGS, 16, architectural register count; wb_wen never asserted for rd==0 or rd>=N_REGS
- REG_ID_W, 5, width of rd field
- TIMEOUT_CYCLES, 255, bus timeout limit (used only with LSU_TIMEOUT_EN)

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  execute presents an op
- req_ready  out  1  high only in IDLE
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- req_rd  in  REG_ID_W  load destination
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wen  out  1  write request
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  store data shifted into byte lane
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  32  read word
- wb_wen  out  1  register file write enable
- wb_rd  out  REG_ID_W  register file destination
- wb_wdata  out  32  aligned, extended load value
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: misaligned, illegal funct3 or timeout

Behaviour:
- Reset state: IDLE. mem_valid, mem_wen, wb_wen, done and err are 0. mem_wstrb, mem_addr, mem_wdata, wb_rd and wb_wdata are 0.
- States: IDLE, REQ, RSP, DONE.
- IDLE: req_ready=1. On req_valid, capture the op.
  - Legal and aligned: go to REQ.
  - Otherwise: go to DONE with err=1 and no bus activity.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
- Illegal funct3: loads 011/110/111; stores 1xx or 011.
- REQ: mem_valid=1. mem_addr, mem_wen, mem_wstrb and mem_wdata are held stable until mem_ready. On mem_ready, go to RSP.
- Store strobes and data:
  - SB: wstrb=1<<a[1:0], wdata=rep4(b)
  - SH: wstrb=a[1]?1100:0011, wdata=rep2(h)
  - SW: wstrb=1111
- Loads: mem_wstrb=0.
- RSP: wait for mem_rvalid; mem_rvalid outside RSP is ignored. On mem_rvalid, register the result and go to DONE.
- Load extract: select byte/halfword by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- DONE (one cycle): done=1, then back to IDLE.
  - wb_wen=1 only for a successful load with rd!=0 and rd<N_REGS.
  - wb_rd and wb_wdata are valid only while wb_wen=1.
  - Stores never write back.
- Latency: accept in cycle 0; mem_valid in cycle 1. With zero-wait bus (mem_ready in cycle 1, rvalid in cycle 2), done/wb_wen come in cycle 3. Errored requests signal done in cycle 1.
- Back-to-back: req_ready returns the cycle after DONE, giving a minimum 4-cycle issue interval.
- Reset mid-operation: immediate return to IDLE and all outputs cleared. A late mem_rvalid is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: an 8-bit+ counter clears on entry to REQ and counts in REQ/RSP. When it reaches TIMEOUT_CYCLES, go to DONE with err=1, no write-back, mem_valid dropped.
- Undefined: no counter; REQ/RSP wait indefinitely.

Test Plan:
- LW addr=0x100, rd=5, mem_rdata=0xDEADBEEF, zero-wait -> cycle 3: wb_wen=1, wb_rd=5, wb_wdata=0xDEADBEEF, done=1, err=0.
- LB addr=0x103 and LBU addr=0x103, rdata=0x80112233 -> 0xFFFFFF80 and 0x00000080 respectively; LH addr=0x102 -> 0xFFFF8011.
- SH addr=0x206, wdata=0x0000ABCD -> mem_addr=0x204, wstrb=1100, mem_wdata=0xABCDABCD, mem_wen=1; done=1, wb_wen=0.
- LW addr=0x101 -> no mem_valid, done=err=1 in cycle 1; LW rd=0 success -> done=1, wb_wen=0.
- mem_ready withheld 3 cycles -> mem_addr/wstrb/wdata stable throughout; reset asserted in RSP -> IDLE, later mem_rvalid produces no done.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: never assert mem_ready -> done=err=1 after 4 cycles, wb_wen=0.
